fetch_bpred_stage: RTL and testbench
====================================

# fetch_bpred_stage

Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction predictor. It also contains the IF/ID pipeline register. The block owns the fetch PC, drives the instruction-memory address, and predicts each fetched PC's successor. It hands pc/pc+4/instruction/prediction to decode, which forwards them into the ID/EX register. Execute resolves branches and returns redirect and training information to this block.

## Interface
- BTB_ENTRIES, default 16: number of BTB/counter entries, power of two, 2..64.
- RESET_PC, default 32'h0000_0000: fetch PC after reset.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous and active-high; sampled only on the rising edge of i_clk.
- StallF  in  1  hold pc_F.
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  load a bubble into the IF/ID register.
- imem_addr  out  32  equals pc_F (combinational).
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle.
- redirect_E  in  1  execute detected a misprediction.
- redirect_pc_E  in  32  correct next PC when redirect_E=1.
- br_valid_E  in  1  a branch/jump resolved in execute this cycle (training strobe).
- br_taken_E  in  1  actual direction.
- br_pc_E  in  32  PC of the resolved branch.
- br_target_E  in  32  actual taken target.
- pc_D  out  32  IF/ID: fetched PC.
- pc_four_D  out  32  IF/ID: fetched PC + 4.
- instr_D  out  32  IF/ID: instruction.
- pred_taken_D  out  1  IF/ID: fetch predicted taken.
- pred_target_D  out  32  IF/ID: predicted next PC (target or pc+4).

## Operation
- Index = pc[IW+1:2], where IW = log2(BTB_ENTRIES). Tag = pc[31:IW+2].
- Each entry holds valid, tag, target[31:0], and ctr[1:0].
- Lookup (combinational on pc_F):
  - hit = valid & tag match.
  - pred_taken_F = hit & ctr[1].
  - pred_next_F = pred_taken_F ? target : pc_F + 4 (32-bit wrap).
- Next pc_F, in priority order:
  1. i_rst → RESET_PC.
  2. redirect_E → redirect_pc_E. Redirect overrides StallF.
  3. StallF → hold.
  4. Otherwise → pred_next_F.
- Training when br_valid_E=1, at the index of br_pc_E:
  - Hit, taken: ctr saturating increment (3 stays 3); target ← br_target_E.
  - Hit, not taken: ctr saturating decrement (0 stays 0).
  - Miss, taken: allocate (overwrite) entry: valid=1, tag, target=br_target_E, ctr=2'b10.
  - Miss, not taken: no change.
- Training is independent of StallF, StallD and FlushD.
- Same-index read/write in one cycle: the lookup sees pre-update contents; the write is visible from the next cycle.
- IF/ID register, in priority order:
  1. i_rst or FlushD → pc_D=0, pc_four_D=0, instr_D=32'h0000_0013 (NOP), pred_taken_D=0, pred_target_D=0.
  2. StallD → hold all fields.
  3. Otherwise → capture pc_F, pc_F+4, imem_rdata, pred_taken_F, pred_next_F.
- FlushD together with StallD: flush wins.
- Reset state:
  - pc_F=RESET_PC, so imem_addr=RESET_PC in the first cycle after reset.
  - All valid=0 and all ctr=2'b01.
  - IF/ID holds the bubble values above.
- Reset asserted mid-operation discards any same-cycle redirect and training.

## Timing
- Fetch to decode latency: 1 cycle. The PC presented in cycle N appears on pc_D in cycle N+1.
- Predicted-taken branch: the target is fetched in the very next cycle, with zero bubbles.
- Mispredict: pc_F=redirect_pc_E one cycle after redirect_E. The hazard unit asserts FlushD (and FlushE downstream) in the same cycle, so the penalty is 2 bubbles.
- The trained state affects the first lookup one cycle after br_valid_E.
- No combinational path from redirect_E or training inputs to any IF/ID output. imem_addr depends only on registered pc_F.

## Configuration
- BPRED_EN defined:
  - BTB and counters are instantiated; prediction operates as above.
- BPRED_EN undefined:
  - No BTB or counter storage; training inputs are ignored.
  - pred_taken_F=0 and pred_next_F=pc_F+4 (static not-taken).
  - pred_taken_D is always 0; redirect, stall and flush behaviour is unchanged.

## Test plan
- Reset then free-run, no stalls: imem_addr 0x0, 0x4, 0x8. pc_D lags one cycle; instr_D=0x00000013 in the first cycle after reset.
- Train br_pc_E=0x40, taken, target 0x100. Later fetch of 0x40 gives next imem_addr=0x100, pred_taken_D=1, pred_target_D=0x100.
- Two more not-taken trainings at 0x40: ctr 2→1→0, and fetch of 0x40 is followed by 0x44.
- Aliasing: with BTB_ENTRIES=16, train 0x40 then 0x80 (same index, different tag). The lookup at 0x40 is a miss.
- StallF=1 and redirect_E=1 (redirect_pc_E=0x200) in the same cycle → pc_F=0x200. FlushD together with StallD → pc_D=0, instr_D=NOP.
- BPRED_EN undefined: repeat the 0x40 training scenario → pc 0x40 is followed by 0x44 and pred_taken_D stays 0.

Source files
------------

// File: rtl/fetch_bpred_stage.sv
// fetch_bpred_stage: instruction-fetch stage owning the fetch PC, with a
// direct-mapped BTB plus 2-bit saturating direction counters, and the IF/ID
// pipeline register feeding decode.
//
// Build option: define BPRED_EN to instantiate the BTB/counter predictor.
// Without it the stage predicts static not-taken (pc+4) and ignores training.
module fetch_bpred_stage #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_E,
    input  logic [31:0] redirect_pc_E,
    input  logic        br_valid_E,
    input  logic        br_taken_E,
    input  logic [31:0] br_pc_E,
    input  logic [31:0] br_target_E,
    output logic [31:0] pc_D,
    output logic [31:0] pc_four_D,
    output logic [31:0] instr_D,
    output logic        pred_taken_D,
    output logic [31:0] pred_target_D
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0] pc_F;
    logic [31:0] pc_four_F;
    logic [31:0] pred_next_F;
    logic        pred_taken_F;
    logic        unused_bpred;

    assign imem_addr = pc_F;
    assign pc_four_F = pc_F + 32'd4;

`ifdef BPRED_EN
    localparam int unsigned IW = $clog2(BTB_ENTRIES);
    localparam int unsigned TW = 30 - IW;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [31:0]            target_q [BTB_ENTRIES];

    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic          lk_hit;
    logic [IW-1:0] tr_idx;
    logic [TW-1:0] tr_tag;
    logic          tr_hit;

    // Lookup on the current fetch PC reads pre-update contents.
    assign lk_idx       = pc_F[IW+1:2];
    assign lk_tag       = pc_F[31:IW+2];
    assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_F = lk_hit && ctr_q[lk_idx][1];
    assign pred_next_F  = pred_taken_F ? target_q[lk_idx] : pc_four_F;

    // Training port addressed by the resolved branch PC.
    assign tr_idx = br_pc_E[IW+1:2];
    assign tr_tag = br_pc_E[31:IW+2];
    assign tr_hit = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

    // Word-aligned PCs: the byte-offset bits never reach the BTB.
    assign unused_bpred = ^br_pc_E[1:0];

    // Valid bits and direction counters: reset, saturating update, allocation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            ctr_q   <= '{default: 2'b01};
        end else if (br_valid_E) begin
            if (tr_hit) begin
                if (br_taken_E) begin
                    if (ctr_q[tr_idx] != 2'b11) begin
                        ctr_q[tr_idx] <= ctr_q[tr_idx] + 2'd1;
                    end
                end else if (ctr_q[tr_idx] != 2'b00) begin
                    ctr_q[tr_idx] <= ctr_q[tr_idx] - 2'd1;
                end
            end else if (br_taken_E) begin
                valid_q[tr_idx] <= 1'b1;
                ctr_q[tr_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target storage: written on every taken resolution (hit refresh or allocate).
    always_ff @(posedge i_clk) begin
        if (!i_rst && br_valid_E && br_taken_E) begin
            tag_q[tr_idx]    <= tr_tag;
            target_q[tr_idx] <= br_target_E;
        end
    end
`else
    // Static not-taken: the successor is always the sequential PC.
    assign pred_taken_F = 1'b0;
    assign pred_next_F  = pc_four_F;
    assign unused_bpred = ^{br_valid_E, br_taken_E, br_pc_E, br_target_E, BTB_ENTRIES};
`endif

    // Fetch PC: reset, then execute redirect (overrides stall), then stall, then prediction.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_F <= RESET_PC;
        end else if (redirect_E) begin
            pc_F <= redirect_pc_E;
        end else if (!StallF) begin
            pc_F <= pred_next_F;
        end
    end

    // IF/ID register: bubble on reset or flush (flush beats stall), hold on stall.
    always_ff @(posedge i_clk) begin
        if (i_rst || FlushD) begin
            pc_D          <= '0;
            pc_four_D     <= '0;
            instr_D       <= NOP_INSTR;
            pred_taken_D  <= 1'b0;
            pred_target_D <= '0;
        end else if (!StallD) begin
            pc_D          <= pc_F;
            pc_four_D     <= pc_four_F;
            instr_D       <= imem_rdata;
            pred_taken_D  <= pred_taken_F;
            pred_target_D <= pred_next_F;
        end
    end

endmodule

// File: tb/tb_fetch_bpred_stage.sv
// Self-checking bench for fetch_bpred_stage. Expected IF/ID contents are
// queued when a fetch is set up and compared after the capturing clock edge.
// Prediction expectations follow the BPRED_EN build option.
module tb_fetch_bpred_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef BPRED_EN
    localparam logic BP = 1'b1;
`else
    localparam logic BP = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst, StallF, StallD, FlushD;
    logic        redirect_E, br_valid_E, br_taken_E;
    logic [31:0] redirect_pc_E, br_pc_E, br_target_E;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pc_D, pc_four_D, instr_D, pred_target_D;
    logic        pred_taken_D;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] four;
        logic [31:0] instr;
        logic        pt;
        logic [31:0] tgt;
    } ifid_t;

    ifid_t sb[$];
    ifid_t got, exp_v;
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic ifid_t fetch_exp(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
        return '{pc: pc, four: pc + 32'd4, instr: mem_word(pc), pt: pt, tgt: tgt};
    endfunction

    function automatic ifid_t bubble();
        return '{pc: 32'd0, four: 32'd0, instr: NOP, pt: 1'b0, tgt: 32'd0};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    always #5 i_clk = ~i_clk;

    fetch_bpred_stage #(
        .BTB_ENTRIES(16),
        .RESET_PC   (RESET_PC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redirect_E   (redirect_E),
        .redirect_pc_E(redirect_pc_E),
        .br_valid_E   (br_valid_E),
        .br_taken_E   (br_taken_E),
        .br_pc_E      (br_pc_E),
        .br_target_E  (br_target_E),
        .pc_D         (pc_D),
        .pc_four_D    (pc_four_D),
        .instr_D      (instr_D),
        .pred_taken_D (pred_taken_D),
        .pred_target_D(pred_target_D)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        redirect_E = 1'b0; redirect_pc_E = '0;
        br_valid_E = 1'b0; br_taken_E = 1'b0; br_pc_E = '0; br_target_E = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        sb.push_back(bubble());
        exp_v = sb.pop_front();
        got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL reset_ifid: got pc=%h four=%h instr=%h pt=%b tgt=%h expected pc=%h four=%h instr=%h pt=%b tgt=%h",
                     got.pc, got.four, got.instr, got.pt, got.tgt, exp_v.pc, exp_v.four, exp_v.instr, exp_v.pt, exp_v.tgt);
        end
        i_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] pc;
            pc = RESET_PC + 32'(4 * k);
            n_checks++;
            if (imem_addr !== pc) begin
                n_fail++;
                $display("FAIL freerun_imem_addr[%0d]: got %h expected %h", k, imem_addr, pc);
            end
            sb.push_back(fetch_exp(pc, 1'b0, pc + 32'd4));
            tick();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL freerun_ifid[%0d]: got pc=%h four=%h instr=%h pt=%b tgt=%h expected pc=%h four=%h instr=%h pt=%b tgt=%h",
                         k, got.pc, got.four, got.instr, got.pt, got.tgt, exp_v.pc, exp_v.four, exp_v.instr, exp_v.pt, exp_v.tgt);
            end
        end
    endtask

    typedef struct packed {
        logic        tv;
        logic [31:0] tpc;
        logic        tk;
        logic [31:0] ttgt;
        logic [31:0] probe;
        logic        pt;
        logic [31:0] nxt;
    } row_t;

    // Each row: train (optional) while redirecting to the probe PC, then fetch the probe.
    task automatic test_btb_training();
        row_t rows[13];
        rows[0]  = '{1'b1, 32'h40, 1'b1, 32'h100, 32'h40, 1'b1, 32'h100};
        rows[1]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40, 1'b0, 32'h0};
        rows[2]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40, 1'b0, 32'h0};
        rows[3]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40, 1'b0, 32'h0};
        rows[4]  = '{1'b1, 32'h40, 1'b1, 32'h100, 32'h40, 1'b0, 32'h0};
        rows[5]  = '{1'b1, 32'h40, 1'b1, 32'h180, 32'h40, 1'b1, 32'h180};
        rows[6]  = '{1'b1, 32'h40, 1'b1, 32'h180, 32'h40, 1'b1, 32'h180};
        rows[7]  = '{1'b1, 32'h40, 1'b1, 32'h180, 32'h40, 1'b1, 32'h180};
        rows[8]  = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h40, 1'b1, 32'h180};
        rows[9]  = '{1'b1, 32'h80, 1'b1, 32'h200, 32'h40, 1'b0, 32'h0};
        rows[10] = '{1'b0, 32'h0,  1'b0, 32'h0,   32'h80, 1'b1, 32'h200};
        rows[11] = '{1'b1, 32'h44, 1'b0, 32'h0,   32'h44, 1'b0, 32'h0};
        rows[12] = '{1'b1, 32'h40, 1'b0, 32'h0,   32'h80, 1'b1, 32'h200};
        for (int r = 0; r < 13; r++) begin
            logic        pt_e;
            logic [31:0] nxt_e;
            pt_e  = BP & rows[r].pt;
            nxt_e = pt_e ? rows[r].nxt : rows[r].probe + 32'd4;
            br_valid_E = rows[r].tv; br_pc_E = rows[r].tpc;
            br_taken_E = rows[r].tk; br_target_E = rows[r].ttgt;
            redirect_E = 1'b1; redirect_pc_E = rows[r].probe; FlushD = 1'b1;
            sb.push_back(bubble());
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL train_flush_ifid[%0d]: got pc=%h instr=%h pt=%b tgt=%h expected pc=%h instr=%h pt=%b tgt=%h",
                         r, got.pc, got.instr, got.pt, got.tgt, exp_v.pc, exp_v.instr, exp_v.pt, exp_v.tgt);
            end
            n_checks++;
            if (imem_addr !== rows[r].probe) begin
                n_fail++;
                $display("FAIL train_redirect_addr[%0d]: got %h expected %h", r, imem_addr, rows[r].probe);
            end
            sb.push_back(fetch_exp(rows[r].probe, pt_e, nxt_e));
            tick();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL train_probe_ifid[%0d]: got pc=%h four=%h instr=%h pt=%b tgt=%h expected pc=%h four=%h instr=%h pt=%b tgt=%h",
                         r, got.pc, got.four, got.instr, got.pt, got.tgt, exp_v.pc, exp_v.four, exp_v.instr, exp_v.pt, exp_v.tgt);
            end
            n_checks++;
            if (imem_addr !== nxt_e) begin
                n_fail++;
                $display("FAIL train_next_addr[%0d]: got %h expected %h", r, imem_addr, nxt_e);
            end
        end
    endtask

    // Training and lookup of the same entry in one cycle: lookup sees the old state.
    task automatic test_same_cycle_rw();
        for (int pass = 0; pass < 2; pass++) begin
            logic        pt_e;
            logic [31:0] nxt_e;
            pt_e  = (pass == 1) ? BP : 1'b0;
            nxt_e = pt_e ? 32'h500 : 32'h304;
            redirect_E = 1'b1; redirect_pc_E = 32'h300; FlushD = 1'b1;
            sb.push_back(bubble());
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL samecyc_flush_ifid[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", pass, got.pc, got.instr, exp_v.pc, exp_v.instr);
            end
            if (pass == 0) begin
                br_valid_E = 1'b1; br_taken_E = 1'b1; br_pc_E = 32'h300; br_target_E = 32'h500;
            end
            sb.push_back(fetch_exp(32'h300, pt_e, nxt_e));
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL samecyc_probe_ifid[%0d]: got pc=%h pt=%b tgt=%h expected pc=%h pt=%b tgt=%h",
                         pass, got.pc, got.pt, got.tgt, exp_v.pc, exp_v.pt, exp_v.tgt);
            end
            n_checks++;
            if (imem_addr !== nxt_e) begin
                n_fail++;
                $display("FAIL samecyc_next_addr[%0d]: got %h expected %h", pass, imem_addr, nxt_e);
            end
        end
    endtask

    // Two taken branches pointing at each other: fetch follows every cycle with no bubbles.
    task automatic test_back_to_back();
        logic [31:0] cur, nxt;
        for (int t = 0; t < 2; t++) begin
            br_valid_E = 1'b1; br_taken_E = 1'b1;
            br_pc_E     = (t == 0) ? 32'h48 : 32'h10;
            br_target_E = (t == 0) ? 32'h10 : 32'h48;
            redirect_E = 1'b1; redirect_pc_E = 32'h10; FlushD = 1'b1;
            sb.push_back(bubble());
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_flush_ifid[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", t, got.pc, got.instr, exp_v.pc, exp_v.instr);
            end
        end
        cur = 32'h10;
        for (int k = 0; k < 6; k++) begin
            nxt = BP ? ((cur == 32'h10) ? 32'h48 : 32'h10) : cur + 32'd4;
            n_checks++;
            if (imem_addr !== cur) begin
                n_fail++;
                $display("FAIL b2b_addr[%0d]: got %h expected %h", k, imem_addr, cur);
            end
            sb.push_back(fetch_exp(cur, BP, nxt));
            tick();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_ifid[%0d]: got pc=%h pt=%b tgt=%h expected pc=%h pt=%b tgt=%h",
                         k, got.pc, got.pt, got.tgt, exp_v.pc, exp_v.pt, exp_v.tgt);
            end
            cur = nxt;
        end
    endtask

    // Redirect beats StallF; StallF/StallD hold; FlushD beats StallD.
    task automatic test_redirect_stall();
        logic [31:0] addr_e [6];
        ifid_t       ifid_e [6];
        addr_e = '{32'h200, 32'h200, 32'h204, 32'h204, 32'h204, 32'h208};
        ifid_e[0] = bubble();
        ifid_e[1] = fetch_exp(32'h200, 1'b0, 32'h204);
        ifid_e[2] = fetch_exp(32'h200, 1'b0, 32'h204);
        ifid_e[3] = fetch_exp(32'h200, 1'b0, 32'h204);
        ifid_e[4] = bubble();
        ifid_e[5] = fetch_exp(32'h204, 1'b0, 32'h208);
        for (int s = 0; s < 6; s++) begin
            clear_inputs();
            case (s)
                0: begin StallF = 1'b1; redirect_E = 1'b1; redirect_pc_E = 32'h200; FlushD = 1'b1; end
                1: StallF = 1'b1;
                3: begin StallF = 1'b1; StallD = 1'b1; end
                4: begin StallF = 1'b1; StallD = 1'b1; FlushD = 1'b1; end
                default: ;
            endcase
            sb.push_back(ifid_e[s]);
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL stall_ifid[%0d]: got pc=%h four=%h instr=%h pt=%b tgt=%h expected pc=%h four=%h instr=%h pt=%b tgt=%h",
                         s, got.pc, got.four, got.instr, got.pt, got.tgt, exp_v.pc, exp_v.four, exp_v.instr, exp_v.pt, exp_v.tgt);
            end
            n_checks++;
            if (imem_addr !== addr_e[s]) begin
                n_fail++;
                $display("FAIL stall_addr[%0d]: got %h expected %h", s, imem_addr, addr_e[s]);
            end
        end
    endtask

    // Reset mid-run drops a same-cycle redirect and training and clears the BTB.
    task automatic test_reset_mid_op();
        i_rst = 1'b1;
        redirect_E = 1'b1; redirect_pc_E = 32'h300;
        br_valid_E = 1'b1; br_taken_E = 1'b1; br_pc_E = 32'h24; br_target_E = 32'h400;
        sb.push_back(bubble());
        tick();
        clear_inputs();
        exp_v = sb.pop_front();
        got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL midrst_ifid: got pc=%h instr=%h expected pc=%h instr=%h", got.pc, got.instr, exp_v.pc, exp_v.instr);
        end
        n_checks++;
        if (imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL midrst_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        for (int p = 0; p < 2; p++) begin
            logic [31:0] probe;
            probe = (p == 0) ? 32'h24 : 32'h10;
            redirect_E = 1'b1; redirect_pc_E = probe; FlushD = 1'b1;
            sb.push_back(bubble());
            tick();
            clear_inputs();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_flush_ifid[%0d]: got pc=%h instr=%h expected pc=%h instr=%h", p, got.pc, got.instr, exp_v.pc, exp_v.instr);
            end
            sb.push_back(fetch_exp(probe, 1'b0, probe + 32'd4));
            tick();
            exp_v = sb.pop_front();
            got = {pc_D, pc_four_D, instr_D, pred_taken_D, pred_target_D};
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_probe_ifid[%0d]: got pc=%h pt=%b tgt=%h expected pc=%h pt=%b tgt=%h",
                         p, got.pc, got.pt, got.tgt, exp_v.pc, exp_v.pt, exp_v.tgt);
            end
            n_checks++;
            if (imem_addr !== probe + 32'd4) begin
                n_fail++;
                $display("FAIL midrst_next_addr[%0d]: got %h expected %h", p, imem_addr, probe + 32'd4);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        i_rst = 1'b1;
        test_reset();
        test_btb_training();
        test_same_cycle_rw();
        test_back_to_back();
        test_redirect_stall();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
